robo_controlador: RTL and testbench
===================================

// Module: robo_controlador
// PURPOSE
//  Robot-side controller for the map/sensor model: reads head/left/under/barrier and issues
//  avancar/girar/remover. Implements left-hand wall following with barrier removal; halts on the
//  black cell. Clocked by the map's ClockRobo (manual or 50 MHz). Sits beside the map block.
// PARAMETERS
//  TURN_RIGHT_STEPS  3   girar pulses for a right turn (girar = 90 deg counter-clockwise)
//  REMOVE_TIMEOUT    15  max remover pulses per barrier before ST_FALHA
//  SETTLE_CYCLES     1   all-low cycles after every command pulse (1..3)
// PORTS
//  Clock50   in   1   robot clock (top level connects ClockRobo)
//  Reset     in   1   asynchronous, active-low reset
//  start     in   1   leaves ST_IDLE (level; sampled only in ST_IDLE)
//  head      in   1   wall/edge directly ahead
//  left      in   1   wall/edge on the left
//  under     in   1   robot is on the black cell
//  barrier   in   1   trash directly ahead
//  avancar   out  1   move-forward pulse (registered)
//  girar     out  1   rotate-left pulse (registered)
//  remover   out  1   remove-trash pulse (registered)
//  done      out  1   high in ST_FIM
//  falha     out  1   high in ST_FALHA
//  estado    out  3   current state code (LED debug)
//  passos    out  16  forward-step count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset low: state ST_IDLE; avancar=girar=remover=0, done=falha=0, estado=0, passos=0,
//    turn and remove counters 0. Reset mid-command drops the pulse immediately.
//  - Outputs registered. Any command is one cycle high, then SETTLE_CYCLES cycles all low
//    (ST_ESPERA) before sensors are resampled. At most one command high per cycle.
//  - Decision priority, every decide state: under > barrier > wall rules.
//  - ST_IDLE(0): start=1 -> ST_BUSCA.
//  - ST_BUSCA(1): no wall on left yet. under->ST_FIM; barrier->ST_REMOVE; head-> turn right
//    (ST_GIRA_DIR); left && !head -> avancar, then ST_SEGUE; else avancar, stay.
//  - ST_SEGUE(2): under->ST_FIM; barrier->ST_REMOVE; !left -> girar, then ST_POS_ESQ;
//    left && !head -> avancar; left && head -> ST_GIRA_DIR.
//  - ST_POS_ESQ(3): after a left turn. barrier->ST_REMOVE; !head -> avancar then ST_SEGUE;
//    head -> ST_SEGUE (no move).
//  - ST_GIRA_DIR(4): issues TURN_RIGHT_STEPS girar pulses, each followed by settle;
//    counter counts 0..TURN_RIGHT_STEPS-1, then returns to ST_SEGUE. Sensors ignored mid-turn.
//  - ST_REMOVE(5): remover pulse per decide cycle while barrier=1; counter increments per
//    pulse. barrier=0 -> return to saved state (BUSCA/SEGUE/POS_ESQ), counter cleared.
//    Counter reaches REMOVE_TIMEOUT with barrier still 1 -> ST_FALHA.
//  - ST_FIM(6): all commands low, done=1; held until reset. ST_FALHA(7): falha=1; held.
//  - ST_ESPERA is a sub-phase (settle counter) of the issuing state, not a distinct code.
//  - start ignored outside ST_IDLE; inputs X-free assumed-sane from map (no synchronizers).
// CONFIGURATION
//  ROBO_CONTADOR_PASSOS_EN defined: passos increments by 1 on every avancar pulse, saturates at
//  16'hFFFF, cleared only by reset. Undefined: passos constant 0, counter not built.
// STRUCTURE
//  robo_pkg: state codes (ST_IDLE..ST_FALHA, 3 bits), command one-hot constants
//  (CMD_NONE/AVANCAR/GIRAR/REMOVER), default parameter values.
//  Sub-module robo_emissor_cmd: takes a command request, produces the registered one-cycle
//  pulse plus SETTLE_CYCLES busy window; FSM waits on its busy flag.
// TESTING
//  1 Reset=0 while avancar high -> all outputs 0 same instant; Reset=1, start=0 10 cycles -> estado=0.
//  2 start=1, head=left=0 -> avancar pulse every 2 cycles (SETTLE=1); left=1 -> estado=2.
//  3 ST_SEGUE, left=1, head=1 -> exactly 3 girar pulses over 6 cycles, no avancar, back to 2.
//  4 ST_SEGUE, left=0 -> girar, settle, avancar (head=0), estado=2; head=1 instead -> no avancar.
//  5 barrier=1 for 6 pulses then 0 -> 6 remover pulses, return to prior state; barrier held
//    -> after 15 pulses falha=1, estado=7.
//  6 under=1 with barrier=1 and head=1 -> ST_FIM, done=1, no further commands for 20 cycles;
//    with ROBO_CONTADOR_PASSOS_EN, passos equals count of avancar pulses observed.

Source files
------------

// File: rtl/robo_pkg.sv
// robo_pkg: shared definitions for the robot-side wall-following controller.
//   estado_t           : 3-bit state codes, also shown on the debug LEDs
//   cmd_t / CMD_*      : one-hot command encoding {remover, girar, avancar}
//   DEF_*              : default parameter values
//   cntWidth()         : counter width able to hold 0..maxVal
package robo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_BUSCA    = 3'd1,
        ST_SEGUE    = 3'd2,
        ST_POS_ESQ  = 3'd3,
        ST_GIRA_DIR = 3'd4,
        ST_REMOVE   = 3'd5,
        ST_FIM      = 3'd6,
        ST_FALHA    = 3'd7
    } estado_t;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_NONE    = 3'b000;
    localparam cmd_t CMD_AVANCAR = 3'b001;
    localparam cmd_t CMD_GIRAR   = 3'b010;
    localparam cmd_t CMD_REMOVER = 3'b100;

    localparam int unsigned DEF_TURN_RIGHT_STEPS = 3;
    localparam int unsigned DEF_REMOVE_TIMEOUT   = 15;
    localparam int unsigned DEF_SETTLE_CYCLES    = 1;

    function automatic int unsigned cntWidth(input int unsigned maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/robo_controlador_if.sv
// robo_controlador_if: sensor/command bundle between the robot controller and the map model.
//   head, left, under, barrier : sensors (map -> robot)
//   avancar, girar, remover    : command pulses (robot -> map)
// master = robot controller side, slave = map side.
interface robo_controlador_if;

    logic head;
    logic left;
    logic under;
    logic barrier;
    logic avancar;
    logic girar;
    logic remover;

    modport master (
        input  head, left, under, barrier,
        output avancar, girar, remover
    );

    modport slave (
        output head, left, under, barrier,
        input  avancar, girar, remover
    );

endinterface

// File: rtl/robo_emissor_cmd.sv
// robo_emissor_cmd: turns a one-hot command request into a registered one-cycle pulse followed
// by SETTLE_CYCLES all-low cycles.
//   Clock50  in  robot clock
//   Reset    in  asynchronous active-low reset (drops a pulse in flight immediately)
//   cmdReq   in  command request, accepted only while busy is low
//   cmdPulse out registered one-hot command pulse
//   busy     out high during the pulse and all but the last settle cycle, so the controller
//                decides on the edge that closes the settle window
module robo_emissor_cmd
    import robo_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic Clock50,
    input  logic Reset,
    input  cmd_t cmdReq,
    output cmd_t cmdPulse,
    output logic busy
);

    localparam int unsigned SettleW = cntWidth(SETTLE_CYCLES);

    cmd_t               pulseQ;
    logic [SettleW-1:0] settleQ;   // settle cycles still to come after the current one

    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            pulseQ  <= CMD_NONE;
            settleQ <= '0;
        end else if (pulseQ != CMD_NONE) begin
            pulseQ  <= CMD_NONE;
            settleQ <= SettleW'(SETTLE_CYCLES - 1);
        end else if (settleQ != '0) begin
            settleQ <= settleQ - SettleW'(1);
        end else begin
            pulseQ <= cmdReq;
        end
    end

    assign cmdPulse = pulseQ;
    assign busy     = (pulseQ != CMD_NONE) || (settleQ != '0);

endmodule

// File: rtl/robo_controlador.sv
// robo_controlador: left-hand wall follower with barrier removal; halts on the black cell.
//   Clock50  in  robot clock (ClockRobo from the map)
//   Reset    in  asynchronous active-low reset
//   start    in  leaves ST_IDLE (sampled only there)
//   roboBus  if  sensors in / command pulses out (master modport)
//   done     out high in ST_FIM
//   falha    out high in ST_FALHA
//   estado   out current state code
//   passos   out forward-step count; only built with ROBO_CONTADOR_PASSOS_EN defined,
//                otherwise constant 0
module robo_controlador
    import robo_pkg::*;
#(
    parameter int unsigned TURN_RIGHT_STEPS = DEF_TURN_RIGHT_STEPS,
    parameter int unsigned REMOVE_TIMEOUT   = DEF_REMOVE_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES    = DEF_SETTLE_CYCLES
) (
    input  logic                      Clock50,
    input  logic                      Reset,
    input  logic                      start,
    robo_controlador_if.master        roboBus,
    output logic                      done,
    output logic                      falha,
    output logic [2:0]                estado,
    output logic [15:0]               passos
);

    localparam int unsigned TurnW = cntWidth(TURN_RIGHT_STEPS - 1);
    localparam int unsigned RemW  = cntWidth(REMOVE_TIMEOUT);

    estado_t          stateQ, stateD;
    estado_t          savedQ, savedD;   // state to resume once the barrier is gone
    logic [TurnW-1:0] turnQ, turnD;
    logic [RemW-1:0]  remQ, remD;
    logic             doneQ, falhaQ;
    cmd_t             cmdReq;
    cmd_t             cmdPulse;
    logic             busy;

    robo_emissor_cmd #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) uEmissor (
        .Clock50  (Clock50),
        .Reset    (Reset),
        .cmdReq   (cmdReq),
        .cmdPulse (cmdPulse),
        .busy     (busy)
    );

    // Decisions happen only while the emitter is idle; a command's follow-up state is entered
    // on the issuing edge, so the settle window is spent waiting in the target state.
    always_comb begin
        stateD = stateQ;
        savedD = savedQ;
        turnD  = turnQ;
        remD   = remQ;
        cmdReq = CMD_NONE;
        if (!busy) begin
            case (stateQ)
                ST_IDLE: begin
                    if (start) stateD = ST_BUSCA;
                end
                ST_BUSCA: begin
                    if (roboBus.under) begin
                        stateD = ST_FIM;
                    end else if (roboBus.barrier) begin
                        stateD = ST_REMOVE;
                        savedD = ST_BUSCA;
                    end else if (roboBus.head) begin
                        stateD = ST_GIRA_DIR;
                        turnD  = '0;
                    end else begin
                        cmdReq = CMD_AVANCAR;
                        if (roboBus.left) stateD = ST_SEGUE;
                    end
                end
                ST_SEGUE: begin
                    if (roboBus.under) begin
                        stateD = ST_FIM;
                    end else if (roboBus.barrier) begin
                        stateD = ST_REMOVE;
                        savedD = ST_SEGUE;
                    end else if (!roboBus.left) begin
                        cmdReq = CMD_GIRAR;
                        stateD = ST_POS_ESQ;
                    end else if (roboBus.head) begin
                        stateD = ST_GIRA_DIR;
                        turnD  = '0;
                    end else begin
                        cmdReq = CMD_AVANCAR;
                    end
                end
                ST_POS_ESQ: begin
                    if (roboBus.under) begin
                        stateD = ST_FIM;
                    end else if (roboBus.barrier) begin
                        stateD = ST_REMOVE;
                        savedD = ST_POS_ESQ;
                    end else begin
                        stateD = ST_SEGUE;
                        if (!roboBus.head) cmdReq = CMD_AVANCAR;
                    end
                end
                ST_GIRA_DIR: begin
                    // Right turn = repeated left turns; sensors are not looked at mid-turn.
                    cmdReq = CMD_GIRAR;
                    if (turnQ == TurnW'(TURN_RIGHT_STEPS - 1)) begin
                        turnD  = '0;
                        stateD = ST_SEGUE;
                    end else begin
                        turnD = turnQ + TurnW'(1);
                    end
                end
                ST_REMOVE: begin
                    if (roboBus.under) begin
                        stateD = ST_FIM;
                    end else if (!roboBus.barrier) begin
                        stateD = savedQ;
                        remD   = '0;
                    end else if (remQ == RemW'(REMOVE_TIMEOUT)) begin
                        stateD = ST_FALHA;
                    end else begin
                        cmdReq = CMD_REMOVER;
                        remD   = remQ + RemW'(1);
                    end
                end
                default: ;   // ST_FIM and ST_FALHA hold until reset
            endcase
        end
    end

    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            stateQ <= ST_IDLE;
            savedQ <= ST_IDLE;
            turnQ  <= '0;
            remQ   <= '0;
            doneQ  <= 1'b0;
            falhaQ <= 1'b0;
        end else begin
            stateQ <= stateD;
            savedQ <= savedD;
            turnQ  <= turnD;
            remQ   <= remD;
            doneQ  <= (stateD == ST_FIM);
            falhaQ <= (stateD == ST_FALHA);
        end
    end

    assign roboBus.avancar = (cmdPulse == CMD_AVANCAR);
    assign roboBus.girar   = (cmdPulse == CMD_GIRAR);
    assign roboBus.remover = (cmdPulse == CMD_REMOVER);
    assign done            = doneQ;
    assign falha           = falhaQ;
    assign estado          = stateQ;

`ifdef ROBO_CONTADOR_PASSOS_EN
    logic [15:0] passosQ;

    always_ff @(posedge Clock50 or negedge Reset) begin
        if (!Reset) begin
            passosQ <= '0;
        end else if (cmdPulse == CMD_AVANCAR && passosQ != 16'hFFFF) begin
            passosQ <= passosQ + 16'd1;
        end
    end

    assign passos = passosQ;
`else
    assign passos = '0;
`endif

endmodule

// File: tb/tb_robo_controlador.sv
// tb_robo_controlador: randomized stimulus against a step-level reference model of the robot
// rules; every cycle compares state code, command pulses, done, falha and passos.
module tb_robo_controlador;

    localparam int unsigned TurnSteps  = 3;
    localparam int unsigned RemTimeout = 15;
    localparam int unsigned Settle     = 1;

    localparam int ModeIdle   = 0;
    localparam int ModeBusca  = 1;
    localparam int ModeSegue  = 2;
    localparam int ModePosEsq = 3;
    localparam int ModeGira   = 4;
    localparam int ModeRemove = 5;
    localparam int ModeFim    = 6;
    localparam int ModeFalha  = 7;

    logic        clk   = 1'b0;
    logic        rstN  = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic        falha;
    logic [2:0]  estado;
    logic [15:0] passos;

    robo_controlador_if bus ();

    robo_controlador #(
        .TURN_RIGHT_STEPS (TurnSteps),
        .REMOVE_TIMEOUT   (RemTimeout),
        .SETTLE_CYCLES    (Settle)
    ) dut (
        .Clock50 (clk),
        .Reset   (rstN),
        .start   (start),
        .roboBus (bus.master),
        .done    (done),
        .falha   (falha),
        .estado  (estado),
        .passos  (passos)
    );

    always #5 clk = ~clk;

    int nVectors     = 0;
    int nMiscompares = 0;

    // Reference model: mode, remembered mode, turns still owed, barrier pulses so far,
    // edges left before the next decision, expected command {remover, girar, avancar}.
    int         mMode, mSaved, mTurnsLeft, mRemoved, mWait, mPassos;
    logic [2:0] mCmd;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic modelReset();
        mMode = ModeIdle; mSaved = ModeIdle; mTurnsLeft = 0; mRemoved = 0;
        mWait = 0; mPassos = 0; mCmd = 3'b000;
    endtask

    task automatic enterRemove(input int from);
        mSaved = from;
        mMode  = ModeRemove;
    endtask

    task automatic modelDecide();
        case (mMode)
            ModeIdle: if (start) mMode = ModeBusca;
            ModeBusca: begin
                if (bus.under) mMode = ModeFim;
                else if (bus.barrier) enterRemove(ModeBusca);
                else if (bus.head) begin mMode = ModeGira; mTurnsLeft = TurnSteps; end
                else begin mCmd = 3'b001; if (bus.left) mMode = ModeSegue; end
            end
            ModeSegue: begin
                if (bus.under) mMode = ModeFim;
                else if (bus.barrier) enterRemove(ModeSegue);
                else if (!bus.left) begin mCmd = 3'b010; mMode = ModePosEsq; end
                else if (bus.head) begin mMode = ModeGira; mTurnsLeft = TurnSteps; end
                else mCmd = 3'b001;
            end
            ModePosEsq: begin
                if (bus.under) mMode = ModeFim;
                else if (bus.barrier) enterRemove(ModePosEsq);
                else begin mMode = ModeSegue; if (!bus.head) mCmd = 3'b001; end
            end
            ModeGira: begin
                mCmd = 3'b010;
                mTurnsLeft--;
                if (mTurnsLeft == 0) mMode = ModeSegue;
            end
            ModeRemove: begin
                if (bus.under) mMode = ModeFim;
                else if (!bus.barrier) begin mMode = mSaved; mRemoved = 0; end
                else if (mRemoved == RemTimeout) mMode = ModeFalha;
                else begin mCmd = 3'b100; mRemoved++; end
            end
            default: ;
        endcase
    endtask

    task automatic modelStep();
        if (mCmd == 3'b001 && mPassos < 65535) mPassos++;
        mCmd = 3'b000;
        if (mWait > 0) begin
            mWait--;
        end else begin
            modelDecide();
            if (mCmd != 3'b000) mWait = Settle;
        end
    endtask

    task automatic compareAll();
        checkEq("estado", {29'd0, estado}, mMode);
        checkEq("cmd", {29'd0, bus.remover, bus.girar, bus.avancar}, {29'd0, mCmd});
        checkEq("done", {31'd0, done}, {31'd0, (mMode == ModeFim)});
        checkEq("falha", {31'd0, falha}, {31'd0, (mMode == ModeFalha)});
`ifdef ROBO_CONTADOR_PASSOS_EN
        checkEq("passos", {16'd0, passos}, mPassos);
`else
        checkEq("passos", {16'd0, passos}, 32'd0);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rstN) modelStep();
        @(negedge clk);
        compareAll();
    endtask

    // Called at a negedge; outputs must clear as soon as reset falls.
    task automatic applyReset();
        rstN = 1'b0;
        #1;
        modelReset();
        compareAll();
        @(posedge clk);
        @(negedge clk);
        compareAll();
        rstN = 1'b1;
    endtask

    task automatic driveSensors(input int prof, input int c);
        bus.head    = ($urandom % 4 == 0);
        bus.left    = ($urandom % 2 == 1);
        bus.barrier = ($urandom % 12 == 0);
        bus.under   = ($urandom % 400 == 0);
        if (prof == 1 && c >= 20) begin
            bus.barrier = 1'b1;   // never cleared: drives the removal timeout
            bus.under   = 1'b0;
        end
        if (prof == 2 && c >= 50) begin
            bus.under   = 1'b1;   // black cell must win over barrier and wall
            bus.barrier = 1'b1;
            bus.head    = 1'b1;
        end
    endtask

    initial begin
        bus.head = 1'b0; bus.left = 1'b0; bus.under = 1'b0; bus.barrier = 1'b0;
        modelReset();
        @(negedge clk);
        applyReset();
        repeat (10) cycle();

        for (int ep = 0; ep < 36; ep++) begin
            start = 1'b1;
            for (int c = 0; c < 200; c++) begin
                driveSensors(ep % 3, c);
                cycle();
                if (c >= 2) start = ($urandom % 2 == 1);
            end
            // Try to land the reset in the middle of a command pulse.
            for (int w = 0; w < 40 && mCmd == 3'b000; w++) begin
                driveSensors(0, 0);
                cycle();
            end
            applyReset();
            start = 1'b0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
